// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Circular FIFO between fetch and decode, with single-cycle flush
//            and registered overflow/underflow pulses.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enqueue,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     dequeue,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     is_full,
    output logic                     is_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int c_AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]         r_head;
    logic [c_AW:0]         r_tail;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_deq_ok;
    logic                  w_enq_ok;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign w_empty  = (r_head == r_tail);
    assign w_full   = (r_head[c_AW-1:0] == r_tail[c_AW-1:0]) &&
                      (r_head[c_AW] != r_tail[c_AW]);

    // A dequeue on a full queue frees the slot the same-cycle enqueue reuses.
    assign w_deq_ok = dequeue & ~w_empty;
    assign w_enq_ok = enqueue & (~w_full | w_deq_ok);

    assign rdata     = r_mem[r_head[c_AW-1:0]];
    assign is_empty  = w_empty;
    assign is_full   = w_full;
    assign count     = r_tail - r_head;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_deq_ok) begin
                r_head <= r_head + 1'b1;
            end
            if (w_enq_ok) begin
                r_tail <= r_tail + 1'b1;
            end
            r_overflow  <= enqueue & ~w_enq_ok;
            r_underflow <= dequeue & w_empty;
        end
    end

    // Storage is deliberately not reset; contents are only observed when valid.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_enq_ok) begin
            r_mem[r_tail[c_AW-1:0]] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Self-checking bench for fetch_queue: vector table, directed
//            corner sequences and randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int c_DEPTH = 8;
    localparam int c_DW    = 64;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            enqueue;
    logic [c_DW-1:0] wdata;
    logic            dequeue;
    logic [c_DW-1:0] rdata;
    logic            is_full;
    logic            is_empty;
    logic [3:0]      count;
    logic            overflow;
    logic            underflow;

    int n_checks;
    int n_errors;

    logic [c_DW-1:0] q_model[$];
    logic            m_ovf;
    logic            m_udf;

    fetch_queue #(.DEPTH(c_DEPTH), .DATA_WIDTH(c_DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enqueue   (enqueue),
        .wdata     (wdata),
        .dequeue   (dequeue),
        .rdata     (rdata),
        .is_full   (is_full),
        .is_empty  (is_empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic            flush;
        logic            enq;
        logic            deq;
        logic [c_DW-1:0] wdata;
        int              cnt;
        logic            emp;
        logic            ful;
        logic            ovf;
        logic            udf;
        logic            chk_rd;
        logic [c_DW-1:0] rd;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [c_DW-1:0] act, input logic [c_DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: a plain queue with occupancy limit DEPTH.
    task automatic model_update();
        bit deq_ok;
        bit enq_ok;
        if (rst || flush) begin
            q_model.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            deq_ok = dequeue && (q_model.size() > 0);
            enq_ok = enqueue && ((q_model.size() < c_DEPTH) || deq_ok);
            m_ovf  = enqueue && !enq_ok;
            m_udf  = dequeue && (q_model.size() == 0);
            if (deq_ok) void'(q_model.pop_front());
            if (enq_ok) q_model.push_back(wdata);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"},     64'(count),     64'(q_model.size()));
        chk({tag, ".is_empty"},  64'(is_empty),  64'(q_model.size() == 0));
        chk({tag, ".is_full"},   64'(is_full),   64'(q_model.size() == c_DEPTH));
        chk({tag, ".overflow"},  64'(overflow),  64'(m_ovf));
        chk({tag, ".underflow"}, 64'(underflow), 64'(m_udf));
        if (q_model.size() > 0) chk({tag, ".rdata"}, rdata, q_model[0]);
    endtask

    task automatic drive(input logic r, input logic f, input logic e, input logic d, input logic [c_DW-1:0] w);
        rst = r; flush = f; enqueue = e; dequeue = d; wdata = w;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, '0);
        step();
        drive(0, 0, 0, 0, '0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        drive(1, 0, 0, 0, '0);

        //          rst flush enq deq wdata     cnt emp ful ovf udf chk rd
        vecs[0]  = '{1, 0, 0, 0, 64'h0,  0, 1, 0, 0, 0, 0, 64'h0};
        vecs[1]  = '{0, 0, 1, 0, 64'hA0, 1, 0, 0, 0, 0, 1, 64'hA0};
        vecs[2]  = '{0, 0, 1, 0, 64'hA1, 2, 0, 0, 0, 0, 1, 64'hA0};
        vecs[3]  = '{0, 0, 1, 0, 64'hA2, 3, 0, 0, 0, 0, 1, 64'hA0};
        vecs[4]  = '{0, 0, 0, 1, 64'h0,  2, 0, 0, 0, 0, 1, 64'hA1};
        vecs[5]  = '{0, 0, 0, 1, 64'h0,  1, 0, 0, 0, 0, 1, 64'hA2};
        vecs[6]  = '{0, 0, 0, 1, 64'h0,  0, 1, 0, 0, 0, 0, 64'h0};
        vecs[7]  = '{0, 0, 0, 1, 64'h0,  0, 1, 0, 0, 1, 0, 64'h0};
        vecs[8]  = '{0, 0, 1, 1, 64'h55, 1, 0, 0, 0, 1, 1, 64'h55};
        vecs[9]  = '{0, 0, 0, 0, 64'h0,  1, 0, 0, 0, 0, 1, 64'h55};
        vecs[10] = '{0, 0, 0, 1, 64'h0,  0, 1, 0, 0, 0, 0, 64'h0};
        vecs[11] = '{0, 0, 1, 0, 64'h66, 1, 0, 0, 0, 0, 1, 64'h66};
        vecs[12] = '{0, 1, 1, 1, 64'h99, 0, 1, 0, 0, 0, 0, 64'h0};

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].enq, vecs[i].deq, vecs[i].wdata);
            step();
            chk($sformatf("vec%0d.count", i),     64'(count),     64'(vecs[i].cnt));
            chk($sformatf("vec%0d.is_empty", i),  64'(is_empty),  64'(vecs[i].emp));
            chk($sformatf("vec%0d.is_full", i),   64'(is_full),   64'(vecs[i].ful));
            chk($sformatf("vec%0d.overflow", i),  64'(overflow),  64'(vecs[i].ovf));
            chk($sformatf("vec%0d.underflow", i), 64'(underflow), 64'(vecs[i].udf));
            if (vecs[i].chk_rd) chk($sformatf("vec%0d.rdata", i), rdata, vecs[i].rd);
        end

        // Fill, then an extra enqueue must be dropped with a one-cycle overflow.
        do_reset();
        for (int i = 0; i < c_DEPTH; i++) begin
            drive(0, 0, 1, 0, 64'h100 + 64'(i));
            step();
        end
        chk("fill.is_full", 64'(is_full), 64'd1);
        chk("fill.count",   64'(count),   64'd8);
        drive(0, 0, 1, 0, 64'hFF);
        step();
        chk("ovf.pulse", 64'(overflow), 64'd1);
        chk("ovf.count", 64'(count),    64'd8);
        drive(0, 0, 0, 0, '0);
        step();
        chk("ovf.clear", 64'(overflow), 64'd0);

        // Full with simultaneous enqueue/dequeue: occupancy constant, order kept.
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 1, 64'h200 + 64'(i));
            step();
            chk("ff.count", 64'(count), 64'd8);
            chk("ff.rdata", rdata, (i < 7) ? 64'h101 + 64'(i) : 64'h200 + 64'(i - 7));
        end
        for (int i = 0; i < c_DEPTH; i++) begin
            chk("drain.rdata", rdata, 64'h200 + 64'(12 + i));
            drive(0, 0, 0, 1, '0);
            step();
        end
        chk("drain.is_empty", 64'(is_empty), 64'd1);

        // Flush with enqueue pending discards everything, no overflow.
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 64'h300 + 64'(i));
            step();
        end
        drive(0, 1, 1, 0, 64'hBAD);
        step();
        chk("flush.is_empty", 64'(is_empty), 64'd1);
        chk("flush.count",    64'(count),    64'd0);
        chk("flush.overflow", 64'(overflow), 64'd0);
        drive(0, 0, 1, 0, 64'h77);
        step();
        chk("flush.rdata", rdata, 64'h77);
        chk("flush.count1", 64'(count), 64'd1);

        // Reset with entries held and enqueue high.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 64'h400 + 64'(i));
            step();
        end
        chk("pre_rst.count", 64'(count), 64'd4);
        drive(1, 0, 1, 1, 64'h500);
        step();
        chk("rst.count",     64'(count),     64'd0);
        chk("rst.is_empty",  64'(is_empty),  64'd1);
        chk("rst.is_full",   64'(is_full),   64'd0);
        chk("rst.overflow",  64'(overflow),  64'd0);
        chk("rst.underflow", 64'(underflow), 64'd0);
        drive(0, 0, 0, 0, '0);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
                  {$urandom, $urandom});
            step();
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
